// File: rtl/bullet_pkg.sv
// Shared definitions for the bullet palette: colour table, pixel type and
// encoder state encoding. The index->RGB lookup reads the same table.
package bullet_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } enc_state_t;

    localparam logic [0:15][11:0] BULLET_PALETTE = {
        12'h000, 12'h985, 12'hFD8, 12'h112,
        12'h112, 12'h332, 12'hFB5, 12'h432,
        12'h222, 12'h863, 12'h764, 12'h433,
        12'h222, 12'hD95, 12'h653, 12'hFD9
    };

endpackage

// File: rtl/rgb444_manhattan_dist.sv
// Combinational |dr|+|dg|+|db| between two RGB444 colours (0..45).
module rgb444_manhattan_dist
    import bullet_pkg::*;
(
    input  rgb444_t     i_a,
    input  rgb444_t     i_b,
    output logic [5:0]  o_dist
);

    function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        logic signed [4:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        // Negative difference: the reversed subtraction is the magnitude.
        return d[4] ? (b - a) : d[3:0];
    endfunction

    logic [3:0] w_dr;
    logic [3:0] w_dg;
    logic [3:0] w_db;

    always_comb begin
        w_dr   = abs_diff(i_a.r, i_b.r);
        w_dg   = abs_diff(i_a.g, i_b.g);
        w_db   = abs_diff(i_a.b, i_b.b);
        o_dist = {2'b00, w_dr} + {2'b00, w_dg} + {2'b00, w_db};
    end

endmodule

// File: rtl/bullet_palette_encoder.sv
// RGB444 -> nearest bullet palette index. Scans one palette entry per clock;
// strict less-than keeps the lowest index on ties.
module bullet_palette_encoder
    import bullet_pkg::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_red,
    input  logic [3:0]  in_green,
    input  logic [3:0]  in_blue,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_index,
    output logic [5:0]  out_dist,
    output logic        out_exact
);

    enc_state_t r_state;
    enc_state_t w_next;

    rgb444_t    r_pix;
    logic [3:0] r_idx;
    logic [5:0] r_best_dist;
    logic [3:0] r_best_idx;
    logic [3:0] r_out_index;
    logic [5:0] r_out_dist;
    logic       r_out_exact;

    rgb444_t    w_entry;
    logic [5:0] w_dist;
    logic       w_better;
    logic [5:0] w_cand_dist;
    logic [3:0] w_cand_idx;
    logic       w_last;

    assign w_entry = rgb444_t'(BULLET_PALETTE[r_idx]);

    rgb444_manhattan_dist u_dist (
        .i_a    (r_pix),
        .i_b    (w_entry),
        .o_dist (w_dist)
    );

    always_comb begin
        w_better    = (w_dist < r_best_dist);
        w_cand_dist = w_better ? w_dist : r_best_dist;
        w_cand_idx  = w_better ? r_idx  : r_best_idx;
        // idx==15 exit comes first, so r_idx never wraps.
        w_last      = (r_idx == 4'd15) || (EARLY_EXIT && (w_dist == 6'd0));
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = SEARCH;
            SEARCH:  if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default:                w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pix       <= '0;
            r_idx       <= '0;
            r_best_dist <= '1;
            r_best_idx  <= '0;
            r_out_index <= '0;
            r_out_dist  <= '0;
            r_out_exact <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_pix       <= '{r: in_red, g: in_green, b: in_blue};
                        r_idx       <= '0;
                        r_best_dist <= '1;
                        r_best_idx  <= '0;
                    end
                end
                SEARCH: begin
                    r_best_dist <= w_cand_dist;
                    r_best_idx  <= w_cand_idx;
                    if (w_last) begin
                        r_out_index <= w_cand_idx;
                        r_out_dist  <= w_cand_dist;
                        r_out_exact <= (w_cand_dist == 6'd0);
                    end else begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && !Reset;
    assign out_valid = (r_state == DONE);
    assign out_index = r_out_index;
    assign out_dist  = r_out_dist;
    assign out_exact = r_out_exact;

endmodule

// File: tb/tb_bullet_palette_encoder.sv
// Directed bench: an early-exit and a fixed-latency encoder share one input
// stream; results, latency, back-pressure and reset abort are checked.
module tb_bullet_palette_encoder;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       in_valid;
    logic [3:0] in_red, in_green, in_blue;
    logic       out_ready;

    logic       e_in_ready, e_out_valid, e_out_exact;
    logic [3:0] e_out_index;
    logic [5:0] e_out_dist;
    logic       f_in_ready, f_out_valid, f_out_exact;
    logic [3:0] f_out_index;
    logic [5:0] f_out_dist;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    bullet_palette_encoder #(.EARLY_EXIT(1'b1)) u_early (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(e_in_ready),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .out_valid(e_out_valid), .out_ready(out_ready), .out_index(e_out_index),
        .out_dist(e_out_dist), .out_exact(e_out_exact)
    );

    bullet_palette_encoder #(.EARLY_EXIT(1'b0)) u_full (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(f_in_ready),
        .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
        .out_valid(f_out_valid), .out_ready(out_ready), .out_index(f_out_index),
        .out_dist(f_out_dist), .out_exact(f_out_exact)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // exp_k: entry of the first exact match, or -1 when there is none.
    task automatic run_pixel(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                             input int exp_idx, input int exp_dist, input int exp_k,
                             input int hold);
        int lat, le, lf, exp_le;
        @(negedge Clk);
        chk("e_ready_idle", e_in_ready, 1);
        chk("f_ready_idle", f_in_ready, 1);
        in_valid = 1'b1; in_red = r; in_green = g; in_blue = b;
        @(posedge Clk);
        @(negedge Clk);
        in_valid = 1'b0;
        chk("e_ready_busy", e_in_ready, 0);
        chk("f_ready_busy", f_in_ready, 0);
        lat = 1; le = 0; lf = 0;
        while (lat <= 40) begin
            if (e_out_valid && le == 0) le = lat;
            if (f_out_valid && lf == 0) lf = lat;
            if (le != 0 && lf != 0) break;
            @(negedge Clk);
            lat++;
        end
        exp_le = (exp_k >= 0) ? exp_k + 2 : 17;
        chk("e_latency", le, exp_le);
        chk("f_latency", lf, 17);
        chk("e_index", e_out_index, exp_idx);
        chk("e_dist", e_out_dist, exp_dist);
        chk("e_exact", e_out_exact, exp_dist == 0);
        chk("f_index", f_out_index, exp_idx);
        chk("f_dist", f_out_dist, exp_dist);
        chk("f_exact", f_out_exact, exp_dist == 0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_red = 4'h0; in_green = 4'h0; in_blue = 4'h0;
            @(negedge Clk);
            chk("bp_e_valid", e_out_valid, 1);
            chk("bp_e_ready", e_in_ready, 0);
            chk("bp_e_index", e_out_index, exp_idx);
            chk("bp_e_dist", e_out_dist, exp_dist);
            chk("bp_f_valid", f_out_valid, 1);
            chk("bp_f_index", f_out_index, exp_idx);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge Clk);
        out_ready = 1'b0;
        chk("e_valid_drop", e_out_valid, 0);
        chk("f_valid_drop", f_out_valid, 0);
        chk("e_ready_back", e_in_ready, 1);
        chk("f_ready_back", f_in_ready, 1);
    endtask

    initial begin
        int seen;
        Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_red = '0; in_green = '0; in_blue = '0;
        repeat (3) @(negedge Clk);
        chk("rst_e_ready", e_in_ready, 0);
        chk("rst_f_ready", f_in_ready, 0);
        chk("rst_e_valid", e_out_valid, 0);
        chk("rst_e_index", e_out_index, 0);
        chk("rst_e_dist", e_out_dist, 0);
        chk("rst_e_exact", e_out_exact, 0);
        chk("rst_f_valid", f_out_valid, 0);
        Reset = 1'b0;

        run_pixel(4'hF, 4'hD, 4'h8,  2, 0,  2, 5);
        run_pixel(4'h1, 4'h1, 4'h2,  3, 0,  3, 0);
        run_pixel(4'h2, 4'h2, 4'h2,  8, 0,  8, 0);
        run_pixel(4'h0, 4'h0, 4'h1,  0, 1, -1, 0);
        run_pixel(4'hF, 4'hF, 4'hF, 15, 8, -1, 0);

        // Abort a scan with a one-cycle reset at accept+5.
        @(negedge Clk);
        in_valid = 1'b1; in_red = 4'hF; in_green = 4'hF; in_blue = 4'hF;
        @(posedge Clk);
        @(negedge Clk);
        in_valid = 1'b0;
        repeat (4) @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("abort_e_ready_rst", e_in_ready, 0);
        chk("abort_f_ready_rst", f_in_ready, 0);
        @(negedge Clk);
        Reset = 1'b0;
        #1;
        chk("abort_e_ready_after", e_in_ready, 1);
        chk("abort_f_ready_after", f_in_ready, 1);
        seen = 0;
        repeat (20) begin
            @(negedge Clk);
            if (e_out_valid || f_out_valid) seen = 1;
        end
        chk("abort_no_result", seen, 0);

        run_pixel(4'h0, 4'h0, 4'h0,  0, 0,  0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
